inst_fetch: RTL and testbench

//  Instruction fetch unit: the requester side of the instruction ROM port.
//  - Owns the PC and drives rom_ce/rom_addr; captures rom_inst in the cycle it is requested.
//  - Hands {pc, inst} to decode over a valid/ready handshake.
//  - Applies branch redirects from decode and flushes wrong-path instructions.

---
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the ROM port and hands {pc, inst} to decode.
// Define IFU_SKID_EN for a 2-entry output FIFO that removes the id_ready -> pc/rom path.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_address,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  logic [31:0] pc;
  logic        can_accept;
  logic        fire;
  logic        pop;

  assign rom_addr = pc;
  assign pop      = if_valid & id_ready;
  assign fire     = rom_ce & can_accept & ~branch_flag;

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce <= 1'b0;
      pc     <= RESET_PC;
    end else begin
      rom_ce <= 1'b1;
      if (branch_flag) begin
        pc <= branch_target_address & 32'hFFFF_FFFC;
      end else if (fire) begin
        pc <= pc + 32'(PC_STEP);
      end
    end
  end

`ifdef IFU_SKID_EN
  logic [1:0]  count;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;

  // Accept depends only on the registered occupancy, never on id_ready.
  assign can_accept = (count != 2'd2);
  assign if_valid   = (count != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= 2'd0;
      if_pc     <= 32'h0;
      if_inst   <= 32'h0;
      // NOTE: the second entry is reset too; it is two words and keeps X out of if_pc after a pop.
      skid_pc   <= 32'h0;
      skid_inst <= 32'h0;
    end else if (branch_flag) begin
      count <= 2'd0;
    end else begin
      case ({fire, pop})
        2'b10: begin
          if (count == 2'd0) begin
            if_pc   <= pc;
            if_inst <= rom_inst;
          end else begin
            skid_pc   <= pc;
            skid_inst <= rom_inst;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            if_pc   <= skid_pc;
            if_inst <= skid_inst;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word goes behind whatever remains.
          if (count == 2'd2) begin
            if_pc     <= skid_pc;
            if_inst   <= skid_inst;
            skid_pc   <= pc;
            skid_inst <= rom_inst;
          end else begin
            if_pc   <= pc;
            if_inst <= rom_inst;
          end
        end
        default: ;
      endcase
    end
  end
`else
  // A pop this cycle frees the single register, so the next word can land on the same edge.
  assign can_accept = ~if_valid | id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else if (branch_flag) begin
      if_valid <= 1'b0;
    end else if (fire) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= rom_inst;
    end else if (pop) begin
      if_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed steps with a queue of expected PCs popped on each handshake.
// ROM word at byte address a is a >> 2; a second instance starts near the top of memory to show the wrap.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_ready = 1'b1;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target_address = 32'h0;

  logic        rom_ce, if_valid;
  logic [31:0] rom_addr, rom_inst, if_pc, if_inst;
  logic        w_rom_ce, w_if_valid;
  logic [31:0] w_rom_addr, w_rom_inst, w_if_pc, w_if_inst;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef IFU_SKID_EN
  localparam logic [31:0] BP_MAX_ADV = 32'd8;
`else
  localparam logic [31:0] BP_MAX_ADV = 32'd4;
`endif

  assign rom_inst   = rom_addr >> 2;
  assign w_rom_inst = w_rom_addr >> 2;

  inst_fetch u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .rom_ce                (rom_ce),
    .rom_addr              (rom_addr),
    .rom_inst              (rom_inst),
    .branch_flag           (branch_flag),
    .branch_target_address (branch_target_address),
    .id_ready              (id_ready),
    .if_valid              (if_valid),
    .if_pc                 (if_pc),
    .if_inst               (if_inst)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk                   (clk),
    .rst                   (rst),
    .rom_ce                (w_rom_ce),
    .rom_addr              (w_rom_addr),
    .rom_inst              (w_rom_inst),
    .branch_flag           (1'b0),
    .branch_target_address (32'h0),
    .id_ready              (1'b1),
    .if_valid              (w_if_valid),
    .if_pc                 (w_if_pc),
    .if_inst               (w_if_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected stream restarts at every reset release or redirect.
  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // Settle, score a handshake that will complete on the coming edge, then step past the edge.
  task automatic tick();
    logic [31:0] e;
    #1;
    if (if_valid && id_ready) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_inst", if_inst, e >> 2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold_pc, hold_inst, start_addr;

    // Reset state
    #1 rst = 1'b0;
    #22;
    check("rst_rom_ce", 32'(rom_ce), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_w_rom_addr", w_rom_addr, 32'hFFFF_FFF8);

    // 1. Start-up latency and steady streaming; wrap on the second instance
    @(negedge clk);
    rst = 1'b1;
    restart(32'h0);
    tick();
    check("st_rom_ce", 32'(rom_ce), 32'd1);
    check("st_no_valid", 32'(if_valid), 32'd0);
    check("st_addr", rom_addr, 32'h0);
    tick();
    check("st_first_valid", 32'(if_valid), 32'd1);
    check("st_first_pc", if_pc, 32'h0);
    check("st_first_inst", if_inst, 32'h0);
    check("wrap_pc0", w_if_pc, 32'hFFFF_FFF8);
    check("wrap_inst0", w_if_inst, 32'h3FFF_FFFE);
    tick();
    check("wrap_pc1", w_if_pc, 32'hFFFF_FFFC);
    check("wrap_inst1", w_if_inst, 32'h3FFF_FFFF);
    tick();
    check("wrap_pc2", w_if_pc, 32'h0000_0000);
    check("wrap_inst2", w_if_inst, 32'h0);
    check("wrap_valid", 32'(w_if_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("steady_valid", 32'(if_valid), 32'd1);
    end

    // 2. Backpressure for 5 cycles
    id_ready   = 1'b0;
    hold_pc    = if_pc;
    hold_inst  = if_inst;
    start_addr = rom_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_pc", if_pc, hold_pc);
      check("bp_hold_inst", if_inst, hold_inst);
      check("bp_valid", 32'(if_valid), 32'd1);
    end
    check("bp_adv_bound", 32'((rom_addr - start_addr) <= BP_MAX_ADV), 32'd1);
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // 3. Branch while streaming: one bubble, then the target sequence
    branch_flag = 1'b1;
    branch_target_address = 32'h0000_0103;
    tick();
    branch_flag = 1'b0;
    restart(32'h0000_0100);
    check("br_addr", rom_addr, 32'h0000_0100);
    check("br_bubble", 32'(if_valid), 32'd0);
    tick();
    check("br_valid", 32'(if_valid), 32'd1);
    check("br_pc", if_pc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) tick();

    // 4. Branch with a full, stalled buffer
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("bs_full_valid", 32'(if_valid), 32'd1);
    branch_flag = 1'b1;
    branch_target_address = 32'h0000_0200;
    tick();
    branch_flag = 1'b0;
    restart(32'h0000_0200);
    check("bs_flushed", 32'(if_valid), 32'd0);
    check("bs_addr", rom_addr, 32'h0000_0200);
    tick();
    check("bs_valid", 32'(if_valid), 32'd1);
    check("bs_pc", if_pc, 32'h0000_0200);
    check("bs_inst", if_inst, 32'h0000_0080);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // 6. Asynchronous reset pulse away from the clock edge
    #3 rst = 1'b0;
    #1;
    check("ar_rom_ce", 32'(rom_ce), 32'd0);
    check("ar_valid", 32'(if_valid), 32'd0);
    check("ar_if_pc", if_pc, 32'h0);
    check("ar_if_inst", if_inst, 32'h0);
    check("ar_rom_addr", rom_addr, 32'h0);
    check("ar_w_valid", 32'(w_if_valid), 32'd0);
    @(posedge clk);
    #1;
    check("ar_hold_rom_ce", 32'(rom_ce), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    restart(32'h0);
    tick();
    check("ar_no_valid", 32'(if_valid), 32'd0);
    tick();
    check("ar_first_valid", 32'(if_valid), 32'd1);
    check("ar_first_pc", if_pc, 32'h0);
    check("ar_w_pc", w_if_pc, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
